// File: rtl/result_checker_multi.sv
`default_nettype none
// ============================================================================
// result_checker_multi : arms on a begin symbol, checks test-port writes
//                        against a loadable table, reports pass/fail/timeout
// Rev 1.0
// ============================================================================
module result_checker_multi #(
   parameter int unsigned        ADDR_W     = 30,
   parameter int unsigned        DATA_W     = 32,
   parameter logic [ADDR_W-1:0]  TEST_PORT  = 30'h10,
   parameter logic [DATA_W-1:0]  BEGIN_SYM  = 32'h00000168,
   parameter int unsigned        MAX_CHECKS = 32,
   parameter bit                 BYTE_SWAP  = 1'b1,
   parameter int unsigned        TIMEOUT    = 16'hFFFF,
   parameter int unsigned        ERR_W      = 8,
   parameter int unsigned        DUR_W      = 16,
   localparam int unsigned       IDX_W      = $clog2(MAX_CHECKS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic [IDX_W-1:0]  check_num,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [DATA_W-1:0] exp_data,
   output logic              busy,
   output logic              finish,
   output logic              timeout,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              first_err_valid,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_data
);

   localparam int unsigned TAB_AW = (MAX_CHECKS > 1) ? $clog2(MAX_CHECKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_REPORT = 2'd2,
      S_TOUT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ERR_W-1:0]    error_num_q, error_num_d;
   logic [DUR_W-1:0]    duration_q, duration_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    n_q, n_d;
   logic                track_q, track_d;
   logic                fe_valid_q, fe_valid_d;
   logic [IDX_W-1:0]    fe_idx_q, fe_idx_d;
   logic [DATA_W-1:0]   fe_data_q, fe_data_d;

   logic [DATA_W-1:0]   tbl_q [MAX_CHECKS];
   logic [DATA_W-1:0]   dmod;
   logic [DATA_W-1:0]   exp_word;
   logic                hit;
   logic                accept;
   logic                tbl_we;

   // The bus is little-endian; the table holds values in readable order.
   generate
      if (BYTE_SWAP) begin : g_swap
         for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
            assign dmod[8*b +: 8] = data[DATA_W-8-8*b +: 8];
         end
      end else begin : g_noswap
         assign dmod = data;
      end
   endgenerate

   assign hit      = wen && (addr == TEST_PORT);
   assign accept   = hit && !track_q;
   assign exp_word = (idx_q < IDX_W'(MAX_CHECKS)) ? tbl_q[idx_q[TAB_AW-1:0]] : '0;
   assign tbl_we   = exp_we && (state_q == S_IDLE) && (exp_idx < IDX_W'(MAX_CHECKS));

   always_ff @(posedge clk) begin
      if (tbl_we) begin
         tbl_q[exp_idx[TAB_AW-1:0]] <= exp_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      error_num_d = error_num_q;
      duration_d  = duration_q;
      idx_d       = idx_q;
      n_d         = n_q;
      track_d     = wen;
      fe_valid_d  = fe_valid_q;
      fe_idx_d    = fe_idx_q;
      fe_data_d   = fe_data_q;
      case (state_q)
         S_IDLE: begin
            if (hit && (dmod == BEGIN_SYM)) begin
               state_d     = S_CHECK;
               error_num_d = '0;
               duration_d  = '0;
               idx_d       = '0;
               fe_valid_d  = 1'b0;
               n_d         = check_num;
            end
         end
         S_CHECK: begin
            // Exit decisions use registered idx; counters freeze on the exit cycle.
            if (idx_q == n_q) begin
               state_d = S_REPORT;
            end else if (duration_q == DUR_W'(TIMEOUT)) begin
               state_d = S_TOUT;
            end else begin
               if (duration_q != '1) duration_d = duration_q + DUR_W'(1);
               if (accept) begin
                  idx_d = idx_q + IDX_W'(1);
                  if (dmod != exp_word) begin
                     if (error_num_q != '1) error_num_d = error_num_q + ERR_W'(1);
                     if (!fe_valid_q) begin
                        fe_valid_d = 1'b1;
                        fe_idx_d   = idx_q;
                        fe_data_d  = dmod;
                     end
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         error_num_q <= '1;
         duration_q  <= '0;
         idx_q       <= '0;
         n_q         <= '0;
         track_q     <= 1'b0;
         fe_valid_q  <= 1'b0;
         fe_idx_q    <= '0;
         fe_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         error_num_q <= error_num_d;
         duration_q  <= duration_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         track_q     <= track_d;
         fe_valid_q  <= fe_valid_d;
         fe_idx_q    <= fe_idx_d;
         fe_data_q   <= fe_data_d;
      end
   end

   assign busy            = (state_q == S_CHECK);
   assign finish          = (state_q == S_REPORT) || (state_q == S_TOUT);
   assign timeout         = (state_q == S_TOUT);
   assign error_num       = error_num_q;
   assign duration        = duration_q;
   assign first_err_valid = fe_valid_q;
   assign first_err_idx   = fe_idx_q;
   assign first_err_data  = fe_data_q;

endmodule
`default_nettype wire

// File: tb/tb_result_checker_multi.sv
`default_nettype none
// Scoreboard bench for result_checker_multi: runs are planned up front, a
// reference result is queued, and a monitor compares when finish rises.
module tb_result_checker_multi;

   localparam int          TO  = 100;
   localparam logic [29:0] TP  = 30'h10;
   localparam logic [31:0] BEG = 32'h00000168;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] addr;
   logic [31:0] data;
   logic        wen;
   logic [5:0]  check_num;
   logic        exp_we;
   logic [5:0]  exp_idx;
   logic [31:0] exp_data;
   logic        busy, finish, timeout, first_err_valid;
   logic [7:0]  error_num;
   logic [15:0] duration;
   logic [5:0]  first_err_idx;
   logic [31:0] first_err_data;

   result_checker_multi #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
      .check_num(check_num), .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data),
      .busy(busy), .finish(finish), .timeout(timeout), .error_num(error_num),
      .duration(duration), .first_err_valid(first_err_valid),
      .first_err_idx(first_err_idx), .first_err_data(first_err_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        tout;
      logic [7:0]  err;
      logic [15:0] dur;
      logic        fev;
      logic [5:0]  fei;
      logic [31:0] fed;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ref_tbl [32];
   logic [29:0] pl_a[$];
   logic [31:0] pl_v[$];
   int          pl_h[$];
   int          pl_g[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; wen = 1'b0; exp_we = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic load_entry(input int i, input logic [31:0] v);
      exp_we = 1'b1; exp_idx = 6'(i); exp_data = v;
      if (i < 32) ref_tbl[i] = v;
      tick();
      exp_we = 1'b0;
   endtask

   task automatic plan_clear();
      pl_a.delete(); pl_v.delete(); pl_h.delete(); pl_g.delete();
   endtask

   task automatic plan_push(input logic [29:0] a, input logic [31:0] v, input int h, input int g);
      pl_a.push_back(a); pl_v.push_back(v); pl_h.push_back(h); pl_g.push_back(g);
   endtask

   task automatic drive_arm(input int n, input int gap, input bit do_we);
      check_num = 6'(n);
      addr = TP; data = bswap(BEG); wen = 1'b1;
      tick();
      wen = 1'b0; addr = '0;
      if (do_we) begin
         exp_we = 1'b1; exp_idx = 6'd0; exp_data = 32'hAAAA5555;
      end
      repeat (gap) tick();
      exp_we = 1'b0;
   endtask

   task automatic drive_plan();
      for (int i = 0; i < pl_a.size(); i++) begin
         addr = pl_a[i]; data = bswap(pl_v[i]); wen = 1'b1;
         repeat (pl_h[i]) tick();
         wen = 1'b0; addr = '0;
         repeat (pl_g[i]) tick();
      end
   endtask

   task automatic wait_finish();
      int budget = 400;
      while (!finish && budget > 0) begin
         tick();
         budget--;
      end
      if (!finish) begin
         checks++; errors++;
         $display("FAIL finish_wait: finish=%b after bounded wait, required 1", finish);
      end
      repeat (2) tick();
   endtask

   // Reference: the n-th in-time test-port write ends the run, else timeout.
   task automatic run(input int n, input int arm_gap, input bit do_we);
      exp_t e;
      int k = arm_gap + 1;
      int idx = 0;
      int done_k = -1;
      e.tout = 1'b0; e.err = 8'd0; e.dur = 16'd0; e.fev = 1'b0; e.fei = 6'd0; e.fed = 32'd0;
      for (int i = 0; i < pl_a.size(); i++) begin
         if (pl_a[i] == TP && idx < n && k <= TO) begin
            if (pl_v[i] != ref_tbl[idx]) begin
               if (e.err != 8'hFF) e.err = e.err + 8'd1;
               if (!e.fev) begin
                  e.fev = 1'b1; e.fei = 6'(idx); e.fed = pl_v[i];
               end
            end
            idx++;
            if (idx == n) done_k = k;
         end
         k += pl_h[i] + pl_g[i];
      end
      if (n == 0) done_k = 0;
      if (done_k >= 0) e.dur = 16'(done_k);
      else begin
         e.tout = 1'b1; e.dur = 16'(TO);
      end
      sb_q.push_back(e);
      drive_arm(n, arm_gap, do_we);
      if (n == 0) check("zero_n_finish", {31'd0, finish}, 32'd1);
      drive_plan();
      wait_finish();
   endtask

   // Monitor: compares against the queued expectation on each rise of finish.
   initial begin : monitor
      bit   seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (finish && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_empty: finish=1 with no expected result queued");
            end else begin
               e = sb_q.pop_front();
               check("timeout", {31'd0, timeout}, {31'd0, e.tout});
               check("busy_at_finish", {31'd0, busy}, 32'd0);
               check("error_num", {24'd0, error_num}, {24'd0, e.err});
               check("duration", {16'd0, duration}, {16'd0, e.dur});
               check("first_err_valid", {31'd0, first_err_valid}, {31'd0, e.fev});
               check("first_err_idx", {26'd0, first_err_idx}, {26'd0, e.fei});
               check("first_err_data", first_err_data, e.fed);
            end
         end else if (!finish) begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      int n;
      rst = 1'b0; wen = 1'b0; addr = '0; data = '0; check_num = '0;
      exp_we = 1'b0; exp_idx = '0; exp_data = '0;
      tick();
      check("rst_error_num", {24'd0, error_num}, 32'h000000FF);
      check("rst_duration", {16'd0, duration}, 32'd0);
      check("rst_flags", {28'd0, busy, finish, timeout, first_err_valid}, 32'd0);
      check("rst_fe_data", first_err_data, 32'd0);
      rst = 1'b1;
      tick();

      // Directed table and a clean pass
      for (int i = 0; i < 19; i++)
         load_entry(i, (i == 1) ? 32'h0000FFFF : (i == 18) ? 32'hFFFFFD5D : 32'd0);
      plan_clear();
      for (int i = 0; i < 19; i++) plan_push(TP, ref_tbl[i], 1, 1);
      run(19, 1, 1'b0);

      // Writes 3 and 7 wrong
      do_reset();
      plan_clear();
      for (int i = 0; i < 19; i++)
         plan_push(TP, (i == 3) ? 32'h12345678 : (i == 7) ? 32'hDEADBEEF : ref_tbl[i], 1, 1);
      run(19, 1, 1'b0);

      // Held wen: each write counted once
      do_reset();
      plan_clear();
      for (int i = 0; i < 19; i++) plan_push(TP, ref_tbl[i], 4, 1);
      run(19, 1, 1'b0);

      // Timeout with second write wrong; counters must stay frozen afterwards
      do_reset();
      plan_clear();
      plan_push(TP, ref_tbl[0], 1, 1);
      plan_push(TP, 32'h00000BAD, 1, 1);
      run(5, 1, 1'b0);
      addr = TP; data = bswap(32'h0000BEEF); wen = 1'b1; tick();
      wen = 1'b0; tick();
      check("tout_frozen_err", {24'd0, error_num}, 32'd1);
      check("tout_frozen_dur", {16'd0, duration}, TO);

      // check_num = 0
      do_reset();
      plan_clear();
      run(0, 1, 1'b0);

      // Reset mid-CHECK, then re-arm on the retained table
      do_reset();
      plan_clear();
      for (int i = 0; i < 5; i++) plan_push(TP, (i == 2) ? 32'h0F0F0F0F : ref_tbl[i], 1, 1);
      drive_arm(19, 1, 1'b0);
      drive_plan();
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid_rst_error_num", {24'd0, error_num}, 32'h000000FF);
      check("mid_rst_flags", {29'd0, busy, finish, first_err_valid}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      plan_clear();
      for (int i = 0; i < 19; i++) plan_push(TP, ref_tbl[i], 1, 1);
      run(19, 1, 1'b0);

      // IDLE filtering, out-of-range table write, CHECK-time exp_we ignored
      do_reset();
      load_entry(32, 32'h55555555);
      plan_clear();
      plan_push(TP, 32'h12345678, 1, 1);
      plan_push(30'h11, BEG, 1, 1);
      drive_plan();
      check("idle_stays", {31'd0, busy}, 32'd0);
      plan_clear();
      for (int i = 0; i < 19; i++) plan_push(TP, ref_tbl[i], 1, 1);
      run(19, 2, 1'b1);

      // Randomised runs
      for (int r = 0; r < 8; r++) begin
         do_reset();
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) load_entry(i, $urandom);
         plan_clear();
         for (int i = 0; i < n + int'($urandom_range(0, 1)); i++) begin
            if ($urandom_range(0, 4) == 0) plan_push(30'h20, $urandom, 1, 1);
            plan_push(TP, (i >= n || $urandom_range(0, 3) == 0) ? $urandom : ref_tbl[i],
                      $urandom_range(1, 3), $urandom_range(1, 2));
         end
         run(n, $urandom_range(1, 2), 1'b0);
      end

      check("sb_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
